// File: rtl/dial_zero_counter_pkg.sv
// dial_zero_counter_pkg: shared FSM state encoding for the dial engines
package dial_zero_counter_pkg;
  typedef enum logic {S_IDLE, S_RUN} state_t;
endpackage

// File: rtl/dial_zero_counter_step.sv
// dial_step: combinational +/-1 modular dial step, wrapping DIAL_MAX <-> 0
module dial_step #(
  parameter int DIAL_MAX   = 99,
  parameter int DIAL_WIDTH = 7
) (
  input  logic [DIAL_WIDTH-1:0] dial,
  input  logic                  dir,
  output logic [DIAL_WIDTH-1:0] next
);
  localparam logic [DIAL_WIDTH-1:0] TOP = DIAL_WIDTH'(DIAL_MAX);
  localparam logic [DIAL_WIDTH-1:0] ONE = DIAL_WIDTH'(1);
  always_comb
    next = dir ? ((dial == TOP) ? '0 : dial + ONE)
               : ((dial == '0) ? TOP : dial - ONE);
endmodule

// File: rtl/dial_zero_counter.sv
// dial_zero_counter: rotation command engine counting dial zero events
module dial_zero_counter
  import dial_zero_counter_pkg::*;
#(
  parameter int INPUT_WIDTH  = 10,
  parameter int OUTPUT_WIDTH = 13,
  parameter int DIAL_INIT    = 50,
  parameter int DIAL_MAX     = 99,
  parameter int DIAL_WIDTH   = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  output logic                    ready,
  input  logic                    step_direction,
  input  logic [INPUT_WIDTH-1:0]  step_count,
  input  logic                    count_mode,
  output logic [DIAL_WIDTH-1:0]   dial_value,
  output logic [OUTPUT_WIDTH-1:0] zero_count,
  output logic                    overflow
);
  localparam int DIAL_MOD = DIAL_MAX + 1;
  localparam logic [INPUT_WIDTH-1:0] REM_MOD = INPUT_WIDTH'(DIAL_MOD);
  localparam logic [INPUT_WIDTH-1:0] REM_ONE = INPUT_WIDTH'(1);
  state_t state, state_next;
  logic [INPUT_WIDTH-1:0] rem, rem_next;
  logic dir, mode, chunk, inc, carry;
  logic [DIAL_WIDTH-1:0] dial_next;
  logic [OUTPUT_WIDTH-1:0] count_inc;
  dial_step #(.DIAL_MAX(DIAL_MAX), .DIAL_WIDTH(DIAL_WIDTH)) u_step (
    .dial(dial_value),
    .dir (dir),
    .next(dial_next)
  );
  // a full revolution is consumed in one cycle and meets zero exactly once
  always_comb begin
    chunk = rem > INPUT_WIDTH'(DIAL_MAX);
    rem_next = chunk ? rem - REM_MOD : rem - REM_ONE;
    inc = (state == S_RUN) && (chunk ? mode : (dial_next == '0) && (mode || rem == REM_ONE));
    {carry, count_inc} = {1'b0, zero_count} + (OUTPUT_WIDTH+1)'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_next;
  always_comb
    state_next = (state == S_IDLE) ? ((valid && step_count != '0) ? S_RUN : S_IDLE)
                                   : ((rem_next == '0) ? S_IDLE : S_RUN);
  always_comb ready = (state == S_IDLE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem <= '0;
      dir <= 1'b0;
      mode <= 1'b0;
      dial_value <= DIAL_WIDTH'(DIAL_INIT);
      zero_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == S_IDLE && valid) begin
        rem <= step_count;
        dir <= step_direction;
        mode <= count_mode;
      end else if (state == S_RUN) begin
        rem <= rem_next;
        if (!chunk) dial_value <= dial_next;
      end
      if (inc) begin
        zero_count <= count_inc;
        overflow <= overflow | carry;
      end
    end
endmodule

// File: tb/tb_dial_zero_counter.sv
// tb_dial_zero_counter: scoreboard bench for the dial engine (default and 3-bit counter instances)
module tb_dial_zero_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid = 1'b0;
  logic step_direction = 1'b0;
  logic [9:0] step_count = '0;
  logic count_mode = 1'b0;
  logic ready, ready3, overflow, overflow3;
  logic [6:0] dial_value, dial_value3;
  logic [12:0] zero_count;
  logic [2:0] zero_count3;
  int checks = 0;
  int errors = 0;
  int m_dial = 50;
  int m_total = 0;
  typedef struct {int dial; int total; int cycles;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  dial_zero_counter dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready),
    .step_direction(step_direction), .step_count(step_count), .count_mode(count_mode),
    .dial_value(dial_value), .zero_count(zero_count), .overflow(overflow)
  );
  dial_zero_counter #(.OUTPUT_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready3),
    .step_direction(step_direction), .step_count(step_count), .count_mode(count_mode),
    .dial_value(dial_value3), .zero_count(zero_count3), .overflow(overflow3)
  );

  task automatic check_state(input string name, input int dial, input int total);
    checks += 5;
    if (dial_value !== 7'(dial)) begin errors++; $display("FAIL %s dial: got %0d want %0d", name, dial_value, dial); end
    if (zero_count !== 13'(total % 8192)) begin errors++; $display("FAIL %s zero_count: got %0d want %0d", name, zero_count, total % 8192); end
    if (overflow !== (total >= 8192)) begin errors++; $display("FAIL %s overflow: got %b want %b", name, overflow, total >= 8192); end
    if (zero_count3 !== 3'(total % 8)) begin errors++; $display("FAIL %s zero_count3: got %0d want %0d", name, zero_count3, total % 8); end
    if (overflow3 !== (total >= 8)) begin errors++; $display("FAIL %s overflow3: got %b want %b", name, overflow3, total >= 8); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_dial = 50;
    m_total = 0;
  endtask

  // model walks every unit step; mode 0 only counts a landing reached by a single step
  task automatic send(input logic d, input int n, input logic m, input bit hold, input string name);
    exp_t e, got;
    int cyc;
    for (int i = 0; i < n; i++) begin
      m_dial = d ? ((m_dial == 99) ? 0 : m_dial + 1) : ((m_dial == 0) ? 99 : m_dial - 1);
      if (m && m_dial == 0) m_total++;
    end
    if (!m && m_dial == 0 && n % 100 != 0) m_total++;
    e.dial = m_dial;
    e.total = m_total;
    e.cycles = n / 100 + n % 100;
    sb.push_back(e);
    @(negedge clk);
    valid = 1'b1;
    step_direction = d;
    step_count = 10'(n);
    count_mode = m;
    @(posedge clk);
    #1;
    if (hold) begin
      step_direction = ~d;
      step_count = 10'd37;
      count_mode = ~m;
    end else valid = 1'b0;
    cyc = 0;
    while (!ready && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    valid = 1'b0;
    got = sb.pop_front();
    checks++;
    if (cyc !== got.cycles) begin errors++; $display("FAIL %s cycles: got %0d want %0d", name, cyc, got.cycles); end
    check_state(name, got.dial, got.total);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b want 1", ready); end
    check_state("reset", 50, 0);
  endtask

  task automatic test_sequence(input logic m);
    int dirs[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
    int cnts[10] = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};
    do_reset();
    for (int i = 0; i < 10; i++) send(dirs[i][0], cnts[i], m, 1'b0, $sformatf("seq_m%0d_%0d", m, i));
    checks += 2;
    if (dial_value !== 7'd32) begin errors++; $display("FAIL seq_final dial: got %0d want 32", dial_value); end
    if (zero_count !== (m ? 13'd6 : 13'd3)) begin errors++; $display("FAIL seq_final zero_count: got %0d want %0d", zero_count, m ? 6 : 3); end
  endtask

  task automatic test_full_turns();
    do_reset();
    send(1'b1, 1000, 1'b1, 1'b0, "r1000_m1");
    send(1'b1, 1000, 1'b0, 1'b0, "r1000_m0");
  endtask

  task automatic test_zero_edges();
    send(1'b0, 50, 1'b0, 1'b0, "to_zero");
    send(1'b1, 0, 1'b1, 1'b0, "r0");
    send(1'b0, 100, 1'b1, 1'b0, "l100_m1");
    send(1'b0, 100, 1'b0, 1'b0, "l100_m0");
    send(1'b1, 1, 1'b1, 1'b0, "r1_m1");
    send(1'b0, 1, 1'b0, 1'b0, "l1_m0");
    send(1'b1, 1, 1'b0, 1'b0, "r1_m0");
  endtask

  task automatic test_back_to_back();
    send(1'b0, 157, 1'b1, 1'b1, "hold_l157");
    send(1'b1, 243, 1'b0, 1'b1, "hold_r243");
    send(1'b1, 43, 1'b1, 1'b0, "after_hold");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    valid = 1'b1;
    step_direction = 1'b1;
    step_count = 10'd500;
    count_mode = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL async_rst ready: got %b want 1", ready); end
    check_state("async_rst", 50, 0);
    @(negedge clk);
    rst = 1'b0;
    m_dial = 50;
    m_total = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    send(1'b1, 800, 1'b1, 1'b0, "r800_wrap");
    send(1'b1, 1, 1'b1, 1'b0, "ovf_sticky");
  endtask

  initial begin
    test_reset();
    test_sequence(1'b0);
    test_sequence(1'b1);
    test_full_turns();
    test_zero_edges();
    test_back_to_back();
    test_async_reset();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
